// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the iterative multiply/divide unit.
//   - op_i encodings (MULT, MULTU, DIV, DIVU)
//   - FSM state encoding (IDLE, CALC, FIX)
//   - iteration count and step-counter width
//   - small decode helpers for the operation select
package muldiv_pkg;

    localparam int unsigned CNT_W      = 6;
    localparam int unsigned STEP_COUNT = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_FIX  = 2'b10;

    // Signed variants take magnitudes and apply a sign fix at the end
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// muldiv_addsub: W-bit adder/subtractor shared by the multiply and divide steps.
//   a_i, b_i : operands
//   sub_i    : 1 = a_i - b_i, 0 = a_i + b_i
//   sum_o    : W-bit result
//   cout_o   : carry out (for subtract: 1 means a_i >= b_i, no borrow)
module muldiv_addsub #(
    parameter int unsigned W = 33
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sub_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic [W-1:0] b_eff;

    // Two's-complement subtract: invert b and inject the +1 as carry in
    assign b_eff = sub_i ? ~b_i : b_i;
    assign {cout_o, sum_o} = (W+1)'(a_i) + (W+1)'(b_eff) + (W+1)'(sub_i);

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: fixed-latency (33 edges) MIPS-style HI/LO multiply/divide unit.
//   clk, reset            : clock, synchronous active-high reset
//   start_i, op_i         : launch MULT/MULTU/DIV/DIVU
//   rs_data_i, rt_data_i  : operand A / dividend, operand B / divisor
//   mthi_i, mtlo_i        : write wr_data_i to HI / LO while idle
//   busy_o                : operation in progress
//   done_o                : one-cycle pulse after HI/LO are written
//   hi_o, lo_o            : architectural HI / LO registers
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [N-1:0] rs_data_i,
    input  logic [N-1:0] rt_data_i,
    input  logic         mthi_i,
    input  logic         mtlo_i,
    input  logic [N-1:0] wr_data_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] hi_o,
    output logic [N-1:0] lo_o
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic [N-1:0]     acc_q, acc_d;     // product high half / partial remainder
    logic [N-1:0]     quo_q, quo_d;     // multiplier -> product low half / dividend -> quotient
    logic [N-1:0]     opb_q, opb_d;     // multiplicand / divisor magnitude
    logic [N-1:0]     rs_raw_q, rs_raw_d;
    logic [N-1:0]     rt_raw_q, rt_raw_d;
    logic [N-1:0]     hi_q, hi_d;
    logic [N-1:0]     lo_q, lo_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             is_div;
    logic [N-1:0]     addend;
    logic [N:0]       as_a, as_b, as_sum;
    logic             as_cout;
    logic [2*N-1:0]   prod;
    logic             start_signed;

    // Shared datapath: divide subtracts the divisor from the shifted remainder,
    // multiply conditionally adds the multiplicand into the high half.
    assign is_div = op_is_div(op_q);
    assign addend = (is_div || quo_q[0]) ? opb_q : {N{1'b0}};
    assign as_a   = is_div ? {acc_q, quo_q[N-1]} : {1'b0, acc_q};
    assign as_b   = {1'b0, addend};

    muldiv_addsub #(.W(N + 1)) u_addsub (
        .a_i    (as_a),
        .b_i    (as_b),
        .sub_i  (is_div),
        .sum_o  (as_sum),
        .cout_o (as_cout)
    );

    assign start_signed = op_is_signed(op_i);

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        opb_d    = opb_q;
        rs_raw_d = rs_raw_q;
        rt_raw_d = rt_raw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        prod     = {acc_q, quo_q};

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    op_d     = op_i;
                    sa_d     = start_signed & rs_data_i[N-1];
                    sb_d     = start_signed & rt_data_i[N-1];
                    quo_d    = (start_signed & rs_data_i[N-1]) ? -rs_data_i : rs_data_i;
                    opb_d    = (start_signed & rt_data_i[N-1]) ? -rt_data_i : rt_data_i;
                    acc_d    = {N{1'b0}};
                    rs_raw_d = rs_data_i;
                    rt_raw_d = rt_data_i;
                    cnt_d    = {CNT_W{1'b0}};
                    state_d  = ST_CALC;
                end else begin
                    if (mthi_i) hi_d = wr_data_i;
                    if (mtlo_i) lo_d = wr_data_i;
                end
            end

            ST_CALC: begin
                if (is_div) begin
                    // Restoring step: keep the difference only if it did not borrow
                    if (as_cout) begin
                        acc_d = as_sum[N-1:0];
                        quo_d = {quo_q[N-2:0], 1'b1};
                    end else begin
                        acc_d = as_a[N-1:0];
                        quo_d = {quo_q[N-2:0], 1'b0};
                    end
                end else begin
                    // Shift {carry, acc, quo} right by one after the add
                    acc_d = as_sum[N:1];
                    quo_d = {as_sum[0], quo_q[N-1:1]};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEP_COUNT - 1)) begin
                    state_d = ST_FIX;
                end
            end

            ST_FIX: begin
                if (!is_div) begin
                    if (sa_q ^ sb_q) prod = -{acc_q, quo_q};
                    hi_d = prod[2*N-1:N];
                    lo_d = prod[N-1:0];
                end else if (rt_raw_q == {N{1'b0}}) begin
                    hi_d = rs_raw_q;
                    lo_d = {N{1'b1}};
                end else begin
                    lo_d = (sa_q ^ sb_q) ? -quo_q : quo_q;
                    hi_d = sa_q ? -acc_q : acc_q;
                end
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= {CNT_W{1'b0}};
            op_q     <= OP_MULT;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            acc_q    <= {N{1'b0}};
            quo_q    <= {N{1'b0}};
            opb_q    <= {N{1'b0}};
            rs_raw_q <= {N{1'b0}};
            rt_raw_q <= {N{1'b0}};
            hi_q     <= {N{1'b0}};
            lo_q     <= {N{1'b0}};
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            opb_q    <= opb_d;
            rs_raw_q <= rs_raw_d;
            rt_raw_q <= rt_raw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign hi_o   = hi_q;
    assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven check of muldiv_unit results, latency, busy
// window, HI/LO hold, move/start interaction and mid-operation reset.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] rs_data_i;
    logic [31:0] rt_data_i;
    logic        mthi_i;
    logic        mtlo_i;
    logic [31:0] wr_data_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_total;
    int n_pass;

    muldiv_unit #(.N(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_i   (start_i),
        .op_i      (op_i),
        .rs_data_i (rs_data_i),
        .rt_data_i (rt_data_i),
        .mthi_i    (mthi_i),
        .mtlo_i    (mtlo_i),
        .wr_data_i (wr_data_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Caller is at a negedge with the unit idle (or in its done cycle).
    // inject_at >= 0 drives start+mthi+mtlo at that cycle of the busy window.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int inject_at, input logic mv_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] hi0, lo0;
        int          lat, busy_n;
        logic        held;
        hi0       = hi_o;
        lo0       = lo_o;
        op_i      = op;
        rs_data_i = a;
        rt_data_i = b;
        start_i   = 1'b1;
        mtlo_i    = mv_lo;
        mthi_i    = 1'b0;
        wr_data_i = 32'hAAAA_5555;
        @(posedge clk);
        lat    = -1;
        busy_n = 0;
        held   = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            start_i = 1'b0;
            mthi_i  = 1'b0;
            mtlo_i  = 1'b0;
            if (n == inject_at) begin
                start_i   = 1'b1;
                mthi_i    = 1'b1;
                mtlo_i    = 1'b1;
                op_i      = OP_DIVU;
                rs_data_i = 32'h1;
                rt_data_i = 32'h1;
                wr_data_i = 32'hDEAD_BEEF;
            end
            if (done_o) begin
                lat = n;
                break;
            end
            if (busy_o) busy_n++;
            if (hi_o !== hi0 || lo_o !== lo0) held = 1'b0;
        end
        check({tag, ".latency"}, 64'(lat), 64'(33));
        check({tag, ".busy_cycles"}, 64'(busy_n), 64'(33));
        check({tag, ".hold"}, 64'(held), 64'(1));
        check({tag, ".hi"}, 64'(hi_o), 64'(exp_hi));
        check({tag, ".lo"}, 64'(lo_o), 64'(exp_lo));
    endtask

    initial begin
        logic seen_done;
        n_total   = 0;
        n_pass    = 0;
        reset     = 1'b1;
        start_i   = 1'b0;
        op_i      = OP_MULT;
        rs_data_i = 32'h0;
        rt_data_i = 32'h0;
        mthi_i    = 1'b0;
        mtlo_i    = 1'b0;
        wr_data_i = 32'h0;

        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF};
        vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{OP_DIVU,  32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
        vecs[6] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[7] = '{OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[8] = '{OP_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000};
        vecs[9] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset.hi", 64'(hi_o), 64'(0));
        check("reset.lo", 64'(lo_o), 64'(0));
        check("reset.busy", 64'(busy_o), 64'(0));
        check("reset.done", 64'(done_o), 64'(0));

        // MTHI and MTLO together
        mthi_i    = 1'b1;
        mtlo_i    = 1'b1;
        wr_data_i = 32'h1234_5678;
        @(negedge clk);
        mthi_i = 1'b0;
        mtlo_i = 1'b0;
        check("move.hi", 64'(hi_o), 64'h1234_5678);
        check("move.lo", 64'(lo_o), 64'h1234_5678);

        // start wins over a same-cycle MTLO; LO holds until the result
        run_op("start_mtlo", OP_MULTU, 32'd3, 32'd4, -1, 1'b1, 32'h0, 32'hC);

        // Back-to-back: each vector launches in the done cycle of the previous one
        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, -1, 1'b0,
                   vecs[i].hi, vecs[i].lo);
        end

        // start + moves during busy are ignored
        run_op("busy_inject", OP_MULTU, 32'd7, 32'd6, 5, 1'b0, 32'h0, 32'h2A);

        // Reset at cycle 10 of a DIVU discards the operation
        @(negedge clk);
        op_i      = OP_DIVU;
        rs_data_i = 32'h0000_1000;
        rt_data_i = 32'h0000_0003;
        start_i   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid.busy_before", 64'(busy_o), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid.busy", 64'(busy_o), 64'(0));
        check("rst_mid.done", 64'(done_o), 64'(0));
        check("rst_mid.hi", 64'(hi_o), 64'(0));
        check("rst_mid.lo", 64'(lo_o), 64'(0));
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen_done = 1'b1;
        end
        check("rst_mid.no_done", 64'(seen_done), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
